// File: rtl/viterbi_frame_ctrl_pkg.sv
// rtl/viterbi_frame_ctrl_pkg.sv - shared state type, default sizes and saturating increment
package viterbi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_TAIL    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int DEF_FRAME_LEN = 256;
  localparam int DEF_TAIL      = 2;
  localparam int DEF_DEC_LAT   = 20;

  // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// rtl/viterbi_frame_ctrl_if.sv - source, encoder, decoder and status signals of the frame controller
interface viterbi_frame_ctrl_if #(
  parameter int CW = 16
) ();
  logic          start;
  logic          abort;
  logic          src_valid;
  logic          src_data;
  logic          src_ready;
  logic          encoder_i;
  logic          enable_encoder_i;
  logic          decoder_o;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] err_count;
  logic [CW-1:0] underrun_count;

  modport master (
    input  start, abort, src_valid, src_data, decoder_o,
    output src_ready, encoder_i, enable_encoder_i, busy, frame_done, err_count, underrun_count
  );

  modport slave (
    output start, abort, src_valid, src_data, decoder_o,
    input  src_ready, encoder_i, enable_encoder_i, busy, frame_done, err_count, underrun_count
  );
endinterface

// File: rtl/viterbi_frame_ctrl_ref_delay.sv
// rtl/viterbi_frame_ctrl_ref_delay.sv - DEPTH-deep {tag, bit} reference delay line with synchronous flush
module viterbi_ref_delay #(
  parameter int DEPTH = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic tag_i,
  input  logic bit_i,
  output logic tag_o,
  output logic bit_o,
  output logic pending_o
);
  localparam logic [DEPTH-1:0] OLDER_MASK = {DEPTH{1'b1}} >> 1;

  logic [DEPTH-1:0] tag_q, tag_d;
  logic [DEPTH-1:0] bit_q, bit_d;

  assign tag_d = (tag_q << 1) | DEPTH'(tag_i);
  assign bit_d = (bit_q << 1) | DEPTH'(bit_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
      bit_q <= '0;
    end else if (flush_i) begin
      tag_q <= '0;
      bit_q <= '0;
    end else begin
      tag_q <= tag_d;
      bit_q <= bit_d;
    end
  end

  assign tag_o = tag_q[DEPTH-1];
  assign bit_o = bit_q[DEPTH-1];
  // A tagged entry still on its way to the output, including the one entering now.
  assign pending_o = tag_i | (|(tag_q & OLDER_MASK));
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// rtl/viterbi_frame_ctrl.sv - frame sequencer feeding the encoder and checking decoder output per frame
module viterbi_frame_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int TAIL      = DEF_TAIL,
  parameter int DEC_LAT   = DEF_DEC_LAT,
  parameter int CW        = 16
) (
  input logic                  clk,
  input logic                  rst,
  viterbi_frame_ctrl_if.master bus
);
  localparam int SLOT_MAX = (FRAME_LEN > TAIL) ? FRAME_LEN : TAIL;
  localparam int SW       = $clog2(SLOT_MAX + 1);
  localparam logic [SW-1:0] PAY_LAST  = SW'(FRAME_LEN - 1);
  localparam logic [SW-1:0] TAIL_LAST = SW'((TAIL > 0) ? TAIL - 1 : 0);

  state_e          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic            enc_q, enc_d, en_q, en_d, tag_q, tag_d;
  logic [CW-1:0]   err_q, err_d, und_q, und_d;
  logic            src_ready, busy, frame_done;
  logic            chk_tag, chk_bit, chk_pending;
  logic            aborting, accept_start;

  assign aborting     = bus.abort && (state_q != ST_IDLE);
  assign accept_start = (state_q == ST_IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (aborting) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (accept_start) state_d = ST_PAYLOAD;
        ST_PAYLOAD: if (slot_q == PAY_LAST) state_d = (TAIL == 0) ? ST_DRAIN : ST_TAIL;
        ST_TAIL:    if (slot_q == TAIL_LAST) state_d = ST_DRAIN;
        ST_DRAIN:   if (!chk_pending) state_d = ST_DONE;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    src_ready  = (state_q == ST_PAYLOAD);
    busy       = (state_q != ST_IDLE);
    frame_done = (state_q == ST_DONE);
    en_d       = 1'b0;
    enc_d      = 1'b0;
    tag_d      = 1'b0;
    if (!aborting) begin
      case (state_q)
        ST_PAYLOAD: begin
          en_d  = 1'b1;
          enc_d = bus.src_valid & bus.src_data;
          tag_d = 1'b1;
        end
        ST_TAIL: en_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Slot counter restarts whenever the state changes, so it serves both payload and tail.
  always_comb begin
    slot_d = '0;
    if ((state_d == state_q) && ((state_q == ST_PAYLOAD) || (state_q == ST_TAIL)))
      slot_d = slot_q + 1'b1;
    err_d = err_q;
    und_d = und_q;
    if (accept_start) begin
      err_d = '0;
      und_d = '0;
    end else begin
      if ((state_q == ST_PAYLOAD) && !bus.src_valid) und_d = CW'(sat_inc(32'(und_q), CW));
      if (chk_tag && (chk_bit != bus.decoder_o))     err_d = CW'(sat_inc(32'(err_q), CW));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      enc_q  <= 1'b0;
      en_q   <= 1'b0;
      tag_q  <= 1'b0;
      err_q  <= '0;
      und_q  <= '0;
    end else begin
      slot_q <= slot_d;
      enc_q  <= enc_d;
      en_q   <= en_d;
      tag_q  <= tag_d;
      err_q  <= err_d;
      und_q  <= und_d;
    end
  end

  // Entries leave the delay line exactly DEC_LAT cycles after their encoder drive cycle.
  viterbi_ref_delay #(.DEPTH(DEC_LAT)) u_ref_delay (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (aborting),
    .tag_i     (tag_q),
    .bit_i     (enc_q),
    .tag_o     (chk_tag),
    .bit_o     (chk_bit),
    .pending_o (chk_pending)
  );

  assign bus.src_ready        = src_ready;
  assign bus.busy             = busy;
  assign bus.frame_done       = frame_done;
  assign bus.encoder_i        = enc_q;
  assign bus.enable_encoder_i = en_q;
  assign bus.err_count        = err_q;
  assign bus.underrun_count   = und_q;
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb/tb_viterbi_frame_ctrl.sv - self-checking bench for viterbi_frame_ctrl against a frame-level model
module tb_viterbi_frame_ctrl;
  localparam int FL     = 8;
  localparam int TL     = 2;
  localparam int DL     = 5;
  localparam int CW     = 16;
  localparam int DONE_T = FL + 2 + ((DL > TL) ? DL : TL);

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  viterbi_frame_ctrl_if #(.CW(CW)) bus ();

  viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL(TL), .DEC_LAT(DL), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input int t);
    check({tag, "_busy"},       t, 32'(bus.busy), 0);
    check({tag, "_enable"},     t, 32'(bus.enable_encoder_i), 0);
    check({tag, "_encoder"},    t, 32'(bus.encoder_i), 0);
    check({tag, "_src_ready"},  t, 32'(bus.src_ready), 0);
    check({tag, "_frame_done"}, t, 32'(bus.frame_done), 0);
    check({tag, "_err"},        t, 32'(bus.err_count), 0);
    check({tag, "_underrun"},   t, 32'(bus.underrun_count), 0);
  endtask

  // One frame, t counted from the start cycle S. Bit vectors are MSB-first: slot k is [FL-1-k].
  task automatic run_frame(input logic [FL-1:0] pay, input logic [FL-1:0] vld, input logic [FL-1:0] flip,
                           input bit tail_inv, input int abort_at, input int end_t,
                           input int mid_start, input int rst_at);
    int            lim, last, k, exp_und, exp_err;
    logic [FL-1:0] eff;
    logic          e_en, e_enc;
    lim  = (abort_at < 0) ? 100000 : abort_at;
    last = (end_t < 0) ? DONE_T + 1 : end_t;
    eff  = pay & vld;
    for (int t = 0; t <= last; t++) begin
      bus.start = (t == 0) || (t == mid_start);
      bus.abort = (t == abort_at);
      if (t >= 1 && t <= FL) begin
        bus.src_valid = vld[FL-t];
        bus.src_data  = pay[FL-t];
      end else begin
        bus.src_valid = 1'($urandom);
        bus.src_data  = 1'($urandom);
      end
      k = t - 2 - DL;
      if (k >= 0 && k < FL)                     bus.decoder_o = eff[FL-1-k] ^ flip[FL-1-k];
      else if (tail_inv && k >= FL && k < FL + TL) bus.decoder_o = 1'b1;
      else                                      bus.decoder_o = 1'($urandom);
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check_quiet("rst_async", t);
        return;
      end
      @(negedge clk);
      e_en  = (t >= 2) && (t <= FL + TL + 1) && (t <= lim);
      e_enc = 1'b0;
      if (e_en && (t - 2 < FL)) e_enc = eff[FL-1-(t-2)];
      check("src_ready",  t, 32'(bus.src_ready), 32'((t >= 1) && (t <= FL) && (t <= lim)));
      check("enable",     t, 32'(bus.enable_encoder_i), 32'(e_en));
      check("encoder",    t, 32'(bus.encoder_i), 32'(e_enc));
      check("busy",       t, 32'(bus.busy), 32'((t >= 1) && (t <= DONE_T) && (t <= lim)));
      check("frame_done", t, 32'(bus.frame_done), 32'((t == DONE_T) && (abort_at < 0)));
      if (t >= 1) begin
        exp_und = 0;
        exp_err = 0;
        for (int j = 0; j < FL; j++) begin
          if (!vld[FL-1-j] && (1 + j < t) && (1 + j <= lim))           exp_und++;
          if (flip[FL-1-j] && (2 + j + DL < t) && (2 + j + DL <= lim)) exp_err++;
        end
        check("underrun_count", t, 32'(bus.underrun_count), exp_und);
        check("err_count",      t, 32'(bus.err_count), exp_err);
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data  = 1'b0;
    bus.decoder_o = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset", 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_frame(8'b10110010, 8'hFF, 8'h00, 1'b0, -1, -1, -1, -1);
    run_frame(8'b10110010, 8'hFF, 8'b00100100, 1'b0, -1, -1, -1, -1);
    run_frame(8'b10110010, 8'hFF, 8'h00, 1'b1, -1, -1, -1, -1);
    run_frame(8'b10110010, 8'b11100111, 8'h00, 1'b0, -1, -1, -1, -1);
    run_frame(8'b10110010, 8'b10111111, 8'h00, 1'b0, 4, 6, -1, -1);
    run_frame(8'($urandom), 8'hFF, 8'h00, 1'b0, -1, -1, -1, -1);
    run_frame(8'($urandom), 8'hFF, 8'($urandom), 1'b0, -1, -1, 3, -1);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    check("idle_start_abort_busy", 0, 32'(bus.busy), 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("idle_start_abort_busy", 1, 32'(bus.busy), 0);
    check("idle_start_abort_ready", 1, 32'(bus.src_ready), 0);
    @(posedge clk);
    #1;

    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, -1, -1, -1, FL + 2);
    @(negedge clk);
    check_quiet("rst_hold", 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_quiet("rst_release", 0);

    for (int i = 0; i < 4; i++)
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), -1, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
- Frame sequencer and checker for the convolutional encoder / channel / Viterbi decoder chain.
- Pulls payload bits from a source with a valid/ready handshake and drives the encoder enable and data.
- Appends trellis-terminating zero tail bits.
- Compares decoder output against a delayed copy of the payload and counts bit errors and source underruns per frame.

Parameters:
- FRAME_LEN, 256, payload bits per frame (>=1).
- TAIL, 2, zero tail bits after payload (constraint length minus 1).
- DEC_LAT, 20, clocks from a bit on encoder_i/enable_encoder_i to its decoded value on decoder_o (>=1).
- CW, 16, width of the error and underrun counters.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  terminate current frame; wins over start in the same cycle
- src_valid  in  1  source has a payload bit
- src_data  in  1  payload bit
- src_ready  out  1  controller accepts payload bit this cycle
- encoder_i  out  1  bit to encoder (registered)
- enable_encoder_i  out  1  encoder enable (registered)
- decoder_o  in  1  decoded bit from the Viterbi decoder
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse; counters final
- err_count  out  CW  payload bit mismatches this frame
- underrun_count  out  CW  payload slots with src_valid low

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters and the tag pipeline cleared. Reset mid-frame is identical to power-up.
- States and transitions:
  - IDLE -> PAYLOAD when start=1 and abort=0; err_count and underrun_count clear on that edge.
  - PAYLOAD -> TAIL after FRAME_LEN slots.
  - TAIL -> DRAIN after TAIL slots. With TAIL=0, go straight to DRAIN.
  - DRAIN -> DONE when the last payload compare completes.
  - DONE -> IDLE after one cycle; frame_done=1 in DONE only.
- PAYLOAD timing:
  - src_ready=1 for exactly FRAME_LEN consecutive cycles, S+1..S+FRAME_LEN, where S is the start cycle.
  - Each slot advances regardless of src_valid; the slot counter is CW-independent, width clog2(FRAME_LEN+1).
  - If src_valid=1: the bit is src_data. If src_valid=0: the bit is 0 and underrun_count increments, saturating at 2^CW-1.
- Output timing:
  - encoder_i and enable_encoder_i are registered. Payload slot k (k=0..FRAME_LEN-1), accepted at cycle S+1+k, appears on the outputs at cycle S+2+k.
  - Tail zeros follow contiguously with enable_encoder_i=1. enable_encoder_i is therefore high for FRAME_LEN+TAIL consecutive cycles, then 0; encoder_i is 0 whenever enable is 0.
- Check pipeline:
  - Shift register of depth DEC_LAT holding {tag, bit}, advancing every cycle. tag=1 only for payload bits; tail bits and idle cycles carry tag=0.
  - When the tag emerges (DEC_LAT cycles after that bit's drive cycle) and decoder_o != bit, err_count increments, saturating.
- DRAIN exits the cycle after the last tagged entry is compared. DONE is at cycle S+FRAME_LEN+DEC_LAT+2, independent of TAIL only if DEC_LAT>TAIL; otherwise DONE follows the TAIL completion.
- Counters hold their values after DONE until the next accepted start.
- abort in any non-IDLE state:
  - Next cycle: state IDLE, enable_encoder_i=0, src_ready=0, tag pipeline flushed.
  - No frame_done pulse; counters keep their partial values.
- start while busy: ignored.

Decomposition:
- Package viterbi_ctrl_pkg:
  - state enum typedef (IDLE, PAYLOAD, TAIL, DRAIN, DONE)
  - default FRAME_LEN, TAIL and DEC_LAT constants
  - saturating-increment function
- One sub-module, viterbi_ref_delay: the parameterised DEC_LAT-deep {tag, bit} delay line with synchronous flush.

Test Plan:
- Clean frame: FRAME_LEN=8, TAIL=2, DEC_LAT=5, source always valid with 10110010, decoder_o driven as payload delayed by 5 clocks.
  - enable_encoder_i high for 10 cycles; encoder_i = 1,0,1,1,0,0,1,0,0,0.
  - frame_done at S+15; err_count=0, underrun_count=0.
- Injected errors: same as clean frame with decoder_o inverted on payload bits 2 and 5.
  - err_count=2 at frame_done.
  - Inverting decoder_o on tail-aligned cycles leaves err_count=0.
- Underrun: src_valid low during slots 3 and 4.
  - Zeros are sent in those slots; underrun_count=2; enable_encoder_i stays contiguous for 10 cycles.
- Abort: assert abort at S+4.
  - busy=0 and enable_encoder_i=0 at S+5; no frame_done; a new start at S+7 clears the counters and runs a clean frame.
- Start while busy and simultaneous events:
  - A start pulse during PAYLOAD has no effect.
  - start and abort together in IDLE: no frame begins.
- Reset mid-frame: assert rst asynchronously during TAIL.
  - All outputs are 0 immediately, before the next clock edge; state is IDLE after release.
